// File: rtl/alu_cmd_scheduler.sv
// alu_cmd_scheduler: command FIFO and single-outstanding issue stage feeding the ALU.
module alu_cmd_scheduler #(
   parameter int DATA_WIDTH = 8,
   parameter int OP_WIDTH   = 4,
   parameter int MOVI_WIDTH = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [OP_WIDTH-1:0]   in_op,
   input  logic [MOVI_WIDTH-1:0] in_movi,
   input  logic [DATA_WIDTH-1:0] in_reg_a,
   input  logic [DATA_WIDTH-1:0] in_mem,
   input  logic [DATA_WIDTH-1:0] in_imm,
   input  logic                  alu_rdy,
   input  logic                  ex_alu_vld,
   output logic                  act,
   output logic [OP_WIDTH-1:0]   op,
   output logic [MOVI_WIDTH-1:0] movi,
   output logic [DATA_WIDTH-1:0] reg_a,
   output logic [DATA_WIDTH-1:0] mem,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  issued_cnt,
   output logic                  err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = OP_WIDTH + MOVI_WIDTH + 3 * DATA_WIDTH;
   localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] fifo [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic          push, pop;

   // Ready comes from the registered count alone, so a pop never frees a slot in the same cycle.
   assign in_rdy = count < FULL;
   assign push   = in_vld & in_rdy;
   assign busy   = state == S_WAIT;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nx;

   always_comb begin
      pop      = (state == S_IDLE) && (count != '0) && alu_rdy;
      state_nx = (state == S_IDLE) ? (pop ? S_WAIT : S_IDLE) : (ex_alu_vld ? S_IDLE : S_WAIT);
   end

   always_ff @(posedge clk)
      if (push) fifo[wr_ptr] <= {in_op, in_movi, in_reg_a, in_mem, in_imm};

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         act        <= 1'b0;
         op         <= '0;
         movi       <= '0;
         reg_a      <= '0;
         mem        <= '0;
         imm        <= '0;
         issued_cnt <= '0;
         err        <= 1'b0;
      end else begin
         wr_ptr     <= wr_ptr + AW'(push);
         rd_ptr     <= rd_ptr + AW'(pop);
         count      <= count + (AW + 1)'(push) - (AW + 1)'(pop);
         act        <= pop;
         issued_cnt <= issued_cnt + CNT_WIDTH'(pop);
         err        <= err | (ex_alu_vld & (state == S_IDLE));
         if (pop) {op, movi, reg_a, mem, imm} <= fifo[rd_ptr];
      end
endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// tb_alu_cmd_scheduler: directed and random traffic against a queue-based model of the scheduler.
module tb_alu_cmd_scheduler;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_vld = 1'b0, in_rdy;
   logic [3:0]  in_op = '0, op;
   logic [1:0]  in_movi = '0, movi;
   logic [7:0]  in_reg_a = '0, in_mem = '0, in_imm = '0, reg_a, mem, imm;
   logic        alu_rdy = 1'b0, ex_alu_vld = 1'b0;
   logic        act, busy, err;
   logic [15:0] issued_cnt;

   int          checks = 0;
   int          failures = 0;

   logic [27:0] q[$];
   logic [27:0] m_last = '0;
   logic        m_out = 1'b0, m_act = 1'b0, m_err = 1'b0;
   logic [15:0] m_cnt = '0;

   alu_cmd_scheduler dut (
      .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
      .in_op(in_op), .in_movi(in_movi), .in_reg_a(in_reg_a), .in_mem(in_mem), .in_imm(in_imm),
      .alu_rdy(alu_rdy), .ex_alu_vld(ex_alu_vld), .act(act),
      .op(op), .movi(movi), .reg_a(reg_a), .mem(mem), .imm(imm),
      .busy(busy), .issued_cnt(issued_cnt), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("act", 32'(act), 32'(m_act));
      chk("busy", 32'(busy), 32'(m_out));
      chk("issued_cnt", 32'(issued_cnt), 32'(m_cnt));
      chk("err", 32'(err), 32'(m_err));
      chk("in_rdy", 32'(in_rdy), 32'(q.size() < 4));
      chk("operands", 32'({op, movi, reg_a, mem, imm}), 32'(m_last));
   endtask

   // One clock: drive inputs, advance the model by the behavioural rules, compare after the edge.
   task automatic step(input logic v, input logic [27:0] c, input logic ar, input logic ex);
      logic full, iss;
      @(negedge clk);
      in_vld = v;
      {in_op, in_movi, in_reg_a, in_mem, in_imm} = c;
      alu_rdy = ar;
      ex_alu_vld = ex;
      full = q.size() == 4;
      chk("in_rdy_pre", 32'(in_rdy), 32'(!full));
      @(posedge clk);
      iss = !m_out && q.size() > 0 && ar;
      if (ex && !m_out) m_err = 1'b1;
      if (iss) begin
         m_last = q.pop_front();
         m_cnt++;
         m_out = 1'b1;
      end else if (ex) m_out = 1'b0;
      m_act = iss;
      if (v && !full) q.push_back(c);
      #1 check_all();
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      q.delete();
      m_out = 1'b0; m_act = 1'b0; m_err = 1'b0; m_cnt = '0; m_last = '0;
      #1 check_all();
      @(negedge clk);
      in_vld = 1'b0; alu_rdy = 1'b0; ex_alu_vld = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_all();
   endtask

   logic [27:0] c2;

   initial begin
      c2 = {4'd3, 2'd0, 8'h12, 8'h00, 8'h05};
      repeat (2) @(posedge clk);
      #1 check_all();
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_all();
      step(0, '0, 0, 0);
      // single command
      step(1, c2, 1, 0);
      step(0, '0, 1, 0);
      chk("t2_act", 32'(act), 32'd1);
      chk("t2_op", 32'(op), 32'd3);
      step(0, '0, 1, 0);
      step(0, '0, 1, 1);
      step(0, '0, 1, 0);
      // overfill: one issues, four fill, sixth refused; drain checks order
      for (int i = 0; i < 6; i++) step(1, 28'($urandom), 1, 0);
      chk("t3_full", 32'(in_rdy), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(0, '0, 1, 1);
         step(0, '0, 1, 0);
      end
      step(0, '0, 1, 1);
      // ALU stalled with two queued
      step(1, 28'($urandom), 0, 0);
      step(1, 28'($urandom), 0, 0);
      for (int i = 0; i < 10; i++) step(0, '0, 0, 0);
      step(0, '0, 1, 0);
      step(0, '0, 1, 0);
      step(0, '0, 1, 1);
      step(0, '0, 1, 0);
      step(0, '0, 1, 1);
      // random traffic
      for (int i = 0; i < 400; i++)
         step(1'($urandom % 2), 28'($urandom), 1'($urandom % 4 != 0),
              m_out ? 1'($urandom % 3 == 0) : 1'($urandom % 24 == 0));
      apply_reset();
      // spurious completion sets a sticky error
      step(0, '0, 0, 1);
      chk("t5_err", 32'(err), 32'd1);
      step(1, 28'($urandom), 1, 0);
      step(0, '0, 1, 0);
      step(0, '0, 1, 1);
      step(0, '0, 0, 0);
      // reset while waiting with three queued
      for (int i = 0; i < 4; i++) step(1, 28'($urandom), 1, 0);
      step(0, '0, 1, 0);
      apply_reset();
      step(1, c2, 1, 0);
      step(0, '0, 1, 0);
      chk("t6_cnt", 32'(issued_cnt), 32'd1);
      step(0, '0, 1, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
